// File: rtl/rotary_value_counter_pkg.sv
// Shared encodings for the rotary value counter: accelerator states and step directions.
`ifndef ROTARY_VALUE_COUNTER_PKG_SV
`define ROTARY_VALUE_COUNTER_PKG_SV
package rotary_value_counter_pkg;

  typedef enum logic {
    ST_SLOW = 1'b0,
    ST_FAST = 1'b1
  } rate_state_t;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

endpackage
`endif

// File: rtl/rotary_value_counter_if.sv
// Step flags, preload request and value/status outputs of the rotary value counter.
interface rotary_value_counter_if #(
  parameter int WIDTH = 8
);
  logic             in_cw;
  logic             in_ccw;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             changed;
  logic             fast;

  modport master (
    output in_cw, in_ccw, load, load_value,
    input  value, changed, fast
  );

  modport slave (
    input  in_cw, in_ccw, load, load_value,
    output value, changed, fast
  );
endinterface

// File: rtl/rotary_value_counter_step_rate_tracker.sv
// Step-rate accelerator: timer since last step, same-direction streak and SLOW/FAST state.
// Latency: state updates on the edge that samples the step; fast is registered.
// Backpressure: none, every accepted step is absorbed in the cycle it arrives.
module rotary_value_counter_step_rate_tracker
  import rotary_value_counter_pkg::*;
#(
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_COUNT  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  dir_t dir,
  input  logic clear,
  output logic fast,
  output logic use_fast
);

  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam int CW = $clog2(ACCEL_COUNT + 1);
  localparam logic [TW-1:0] WIN    = TW'(ACCEL_WINDOW);
  localparam logic [TW-1:0] WIN_M1 = TW'(ACCEL_WINDOW - 1);
  localparam logic [CW-1:0] CNT    = CW'(ACCEL_COUNT);
  localparam logic [CW-1:0] ONE    = CW'(1);

  rate_state_t   state;
  logic [TW-1:0] timer;
  logic [CW-1:0] streak;
  logic [CW-1:0] streak_nxt;
  dir_t          last_dir;
  logic          cont;

  assign cont = (timer < WIN) && (dir == last_dir);

  always_comb begin
    streak_nxt = ONE;
    if (cont) begin
      streak_nxt = (streak == CNT) ? CNT : streak + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ST_SLOW;
      timer    <= WIN;
      streak   <= '0;
      last_dir <= DIR_CW;
    end else if (step) begin
      timer    <= '0;
      streak   <= streak_nxt;
      last_dir <= dir;
      // A reversal or a stale step always drops back to SLOW.
      state    <= (cont && streak_nxt == CNT) ? ST_FAST : ST_SLOW;
    end else if (timer != WIN) begin
      timer <= timer + 1'b1;
      if (timer == WIN_M1) begin
        state <= ST_SLOW;
      end
    end
  end

  assign fast = (state == ST_FAST);
  // A reversal taken while FAST still moves by one.
  assign use_fast = fast && (dir == last_dir);

endmodule

// File: rtl/rotary_value_counter.sv
// Bounded user value driven by rotary step flags, with velocity acceleration and preload.
// Latency: value/changed/fast update on the edge that samples the event, visible next cycle.
// Backpressure: none, steps arriving together with load or with each other are dropped.
module rotary_value_counter
  import rotary_value_counter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_VALUE    = 0,
  parameter int MAX_VALUE    = 255,
  parameter int RESET_VALUE  = 0,
  parameter int WRAP         = 0,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_COUNT  = 3,
  parameter int ACCEL_STEP   = 4
) (
  input logic               clk,
  input logic               rst,
  rotary_value_counter_if.slave bus
);

  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] MIN_S   = SW'(MIN_VALUE);
  localparam logic signed [SW-1:0] MAX_S   = SW'(MAX_VALUE);
  localparam logic signed [SW-1:0] RANGE_S = SW'(MAX_VALUE - MIN_VALUE + 1);
  localparam logic signed [SW-1:0] STEP_S  = SW'(ACCEL_STEP);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);

  logic [WIDTH-1:0] value_q;
  logic             changed_q;
  logic             step_acc;
  dir_t             dir;
  logic             fast;
  logic             use_fast;

  logic signed [SW-1:0] cur_s, step_s, sum_s, off_s, nxt_s, ld_s, ld_clamp_s;
  logic [WIDTH-1:0]     nxt_val, ld_val;

  assign step_acc = (bus.in_cw ^ bus.in_ccw) && !bus.load;
  assign dir      = bus.in_ccw ? DIR_CCW : DIR_CW;

  rotary_value_counter_step_rate_tracker #(
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .ACCEL_COUNT  (ACCEL_COUNT)
  ) u_step_rate_tracker (
    .clk      (clk),
    .rst      (rst),
    .step     (step_acc),
    .dir      (dir),
    .clear    (bus.load),
    .fast     (fast),
    .use_fast (use_fast)
  );

  // Two guard bits keep value +/- step and the wrap correction free of overflow.
  always_comb begin
    cur_s  = signed'({2'b00, value_q});
    step_s = use_fast ? STEP_S : ONE_S;
    sum_s  = bus.in_cw ? (cur_s + step_s) : (cur_s - step_s);
    off_s  = sum_s - MIN_S;
    nxt_s  = sum_s;
    if (WRAP != 0) begin
      if (off_s[SW-1]) begin
        nxt_s = sum_s + RANGE_S;
      end else if (off_s >= RANGE_S) begin
        nxt_s = sum_s - RANGE_S;
      end
    end else begin
      if (sum_s < MIN_S) begin
        nxt_s = MIN_S;
      end else if (sum_s > MAX_S) begin
        nxt_s = MAX_S;
      end
    end
    nxt_val = nxt_s[WIDTH-1:0];

    ld_s       = signed'({2'b00, bus.load_value});
    ld_clamp_s = ld_s;
    if (ld_s < MIN_S) begin
      ld_clamp_s = MIN_S;
    end else if (ld_s > MAX_S) begin
      ld_clamp_s = MAX_S;
    end
    ld_val = ld_clamp_s[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= WIDTH'(RESET_VALUE);
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (bus.load) begin
        value_q   <= ld_val;
        changed_q <= (ld_val != value_q);
      end else if (step_acc) begin
        value_q   <= nxt_val;
        changed_q <= (nxt_val != value_q);
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.changed = changed_q;
  assign bus.fast    = fast;

endmodule

// File: tb/tb_rotary_value_counter.sv
// Directed bench for rotary_value_counter: a saturating and a wrapping instance, table-driven.
module tb_rotary_value_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rotary_value_counter_if #(.WIDTH(8)) sif ();
  rotary_value_counter_if #(.WIDTH(8)) wif ();

  rotary_value_counter #(
    .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(20), .RESET_VALUE(10), .WRAP(0),
    .ACCEL_WINDOW(10), .ACCEL_COUNT(3), .ACCEL_STEP(4)
  ) dut_sat (.clk(clk), .rst(rst), .bus(sif.slave));

  rotary_value_counter #(
    .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(20), .RESET_VALUE(0), .WRAP(1),
    .ACCEL_WINDOW(10), .ACCEL_COUNT(3), .ACCEL_STEP(4)
  ) dut_wrap (.clk(clk), .rst(rst), .bus(wif.slave));

  typedef struct {
    bit         w;    // 0: saturating instance, 1: wrapping instance
    bit         cw;
    bit         ccw;
    bit         ld;
    logic [7:0] lv;
    int         gap;  // idle cycles after the check
    logic [7:0] ev;
    bit         ec;
    bit         ef;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit w, input bit cw, input bit ccw, input bit ld, input logic [7:0] lv);
    if (w) begin
      wif.in_cw = cw; wif.in_ccw = ccw; wif.load = ld; wif.load_value = lv;
    end else begin
      sif.in_cw = cw; sif.in_ccw = ccw; sif.load = ld; sif.load_value = lv;
    end
  endtask

  // Entered and left at a negative edge; the event is sampled by the posedge in between.
  task automatic apply(input vec_t v, input int idx);
    bit extra_chg;
    drive(v.w, v.cw, v.ccw, v.ld, v.lv);
    @(negedge clk);
    drive(v.w, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("value",   idx, v.w ? wif.value   : sif.value,   32'(v.ev));
    chk("changed", idx, v.w ? wif.changed : sif.changed, 32'(v.ec));
    chk("fast",    idx, v.w ? wif.fast    : sif.fast,    32'(v.ef));
    extra_chg = 1'b0;
    for (int i = 0; i < v.gap; i++) begin
      @(negedge clk);
      if ((v.w ? wif.changed : sif.changed) !== 1'b0) extra_chg = 1'b1;
    end
    if (v.gap > 0) chk("changed_once", idx, 32'(extra_chg), 32'd0);
  endtask

  initial begin
    //          w  cw ccw ld lv      gap ev      ec ef
    // saturation at MAX
    tbl[0]  = '{0, 0, 0, 1, 8'd19, 20, 8'd19, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'd0,  19, 8'd20, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 8'd0,  19, 8'd20, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 8'd0,  19, 8'd20, 0, 0};
    // acceleration, then timeout back to SLOW
    tbl[4]  = '{0, 0, 0, 1, 8'd0,  12, 8'd0,  1, 0};
    tbl[5]  = '{0, 1, 0, 0, 8'd0,   4, 8'd1,  1, 0};
    tbl[6]  = '{0, 1, 0, 0, 8'd0,   4, 8'd2,  1, 0};
    tbl[7]  = '{0, 1, 0, 0, 8'd0,   4, 8'd3,  1, 1};
    tbl[8]  = '{0, 1, 0, 0, 8'd0,   4, 8'd7,  1, 1};
    tbl[9]  = '{0, 1, 0, 0, 8'd0,  11, 8'd11, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 8'd0,   0, 8'd11, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 8'd0,  12, 8'd12, 1, 0};
    // reversal out of FAST, re-acceleration, saturation at MIN
    tbl[12] = '{0, 0, 0, 1, 8'd0,   4, 8'd0,  1, 0};
    tbl[13] = '{0, 1, 0, 0, 8'd0,   4, 8'd1,  1, 0};
    tbl[14] = '{0, 1, 0, 0, 8'd0,   4, 8'd2,  1, 0};
    tbl[15] = '{0, 1, 0, 0, 8'd0,   4, 8'd3,  1, 1};
    tbl[16] = '{0, 1, 0, 0, 8'd0,   4, 8'd7,  1, 1};
    tbl[17] = '{0, 0, 1, 0, 8'd0,   4, 8'd6,  1, 0};
    tbl[18] = '{0, 0, 1, 0, 8'd0,   4, 8'd5,  1, 0};
    tbl[19] = '{0, 0, 1, 0, 8'd0,   4, 8'd4,  1, 1};
    tbl[20] = '{0, 0, 1, 0, 8'd0,   4, 8'd0,  1, 1};
    // load beats a step and is clamped; both flags high is ignored
    tbl[21] = '{0, 1, 0, 1, 8'd30,  2, 8'd20, 1, 0};
    tbl[22] = '{0, 1, 1, 0, 8'd0,   2, 8'd20, 0, 0};
    tbl[23] = '{0, 0, 0, 1, 8'd5,   2, 8'd5,  1, 0};
    tbl[24] = '{0, 1, 0, 0, 8'd0,   2, 8'd6,  1, 0};
    tbl[25] = '{0, 1, 0, 0, 8'd0,   2, 8'd7,  1, 0};
    tbl[26] = '{0, 1, 1, 0, 8'd0,   2, 8'd7,  0, 0};
    tbl[27] = '{0, 1, 0, 0, 8'd0,   4, 8'd8,  1, 1};
    // wrapping instance
    tbl[28] = '{1, 0, 0, 1, 8'd0,   2, 8'd0,  0, 0};
    tbl[29] = '{1, 0, 1, 0, 8'd0,  19, 8'd20, 1, 0};
    tbl[30] = '{1, 1, 0, 0, 8'd0,  19, 8'd0,  1, 0};
    tbl[31] = '{1, 0, 0, 1, 8'd17,  4, 8'd17, 1, 0};
    tbl[32] = '{1, 1, 0, 0, 8'd0,   4, 8'd18, 1, 0};
    tbl[33] = '{1, 1, 0, 0, 8'd0,   4, 8'd19, 1, 0};
    tbl[34] = '{1, 1, 0, 0, 8'd0,   4, 8'd20, 1, 1};
    tbl[35] = '{1, 1, 0, 0, 8'd0,   4, 8'd3,  1, 1};
    tbl[36] = '{1, 0, 1, 0, 8'd0,   4, 8'd2,  1, 0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_value",   0, sif.value,   32'd10);
    chk("rst_changed", 0, sif.changed, 32'd0);
    chk("rst_fast",    0, sif.fast,    32'd0);
    chk("rst_wvalue",  0, wif.value,   32'd0);
    repeat (5) @(negedge clk);
    chk("idle_value",   0, sif.value,   32'd10);
    chk("idle_changed", 0, sif.changed, 32'd0);

    for (int i = 0; i < NV; i++) apply(tbl[i], i);

    // Reset while FAST: everything returns to SLOW with a fresh streak.
    apply('{0, 0, 0, 1, 8'd0, 2, 8'd0, 1, 0}, 100);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd1, 1, 0}, 101);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd2, 1, 0}, 102);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd3, 1, 1}, 103);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_value",   104, sif.value,   32'd10);
    chk("midrst_fast",    104, sif.fast,    32'd0);
    chk("midrst_changed", 104, sif.changed, 32'd0);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd11, 1, 0}, 105);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd12, 1, 0}, 106);
    apply('{0, 1, 0, 0, 8'd0, 2, 8'd13, 1, 1}, 107);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
